// File: rtl/diad_pkg.sv
// Shared definitions for the diad core: data width, opcode space and the
// fetch-queue entry layout.
package diad_pkg;

    localparam int WORD_W = 24;

    typedef enum logic [5:0] {
        OP_NOP    = 6'h00,
        OP_ALU    = 6'h01,
        OP_LOAD   = 6'h02,
        OP_STORE  = 6'h03,
        OP_BRANCH = 6'h04,
        OP_JUMP   = 6'h05
    } opcode_t;

    // An all-zero word decodes as OP_NOP with every operand field zero.
    localparam logic [WORD_W-1:0] NOP_INSTR = {OP_NOP, 18'h00000};

    typedef struct packed {
        logic [23:0] pc;
        logic [23:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer_ram.sv
// Entry storage for the fetch queue: one write port, one asynchronous read
// port, no reset on the array (stale contents are masked by occupancy).
module fetch_buffer_ram import diad_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int W     = $bits(fetch_entry_t)
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_buffer.sv
// Fetch queue between IF and ID: first-word fall-through FIFO of {pc, instr}
// pairs with flush on taken branch and a NOP presented while empty.
module fetch_buffer #(
    parameter int                DEPTH     = 4,
    parameter int                WORD_W    = diad_pkg::WORD_W,
    parameter logic [WORD_W-1:0] NOP_INSTR = diad_pkg::NOP_INSTR
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [WORD_W-1:0]          push_pc,
    input  logic [WORD_W-1:0]          push_instr,
    output logic                       pop_valid,
    input  logic                       pop_ready,
    output logic [WORD_W-1:0]          pop_pc,
    output logic [WORD_W-1:0]          pop_instr,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_ptr;
    logic [CW-1:0]       next_count;
    logic                push_fire;
    logic                pop_fire;
    logic [2*WORD_W-1:0] head;
    logic [WORD_W-1:0]   head_pc;
    logic [WORD_W-1:0]   head_instr;

    // A transfer happens on a clk edge only when valid and ready are both high;
    // the producer holds its word until it sees ready, and ready never depends
    // combinationally on the consumer side.
    assign push_fire = push_valid && push_ready;
    assign pop_fire  = pop_valid && pop_ready;

    always_comb begin
        next_count = count;
        if (flush) begin
            next_count = '0;
        end else begin
            case ({push_fire, pop_fire})
                2'b10:   next_count = count + CW'(1);
                2'b01:   next_count = count - CW'(1);
                default: next_count = count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            push_ready <= 1'b1;
            overflow   <= 1'b0;
        end else begin
            if (push_valid && !push_ready) begin
                overflow <= 1'b1;
            end
            count      <= next_count;
            push_ready <= (next_count < FULL_COUNT);
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push_fire) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop_fire) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
            end
        end
    end

    fetch_buffer_ram #(
        .DEPTH (DEPTH),
        .W     (2*WORD_W)
    ) u_ram (
        .clk   (clk),
        .we    (push_fire && !flush),
        .waddr (wr_ptr),
        .wdata ({push_pc, push_instr}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    assign {head_pc, head_instr} = head;

    // Unwritten or stale slots are never exposed: empty forces pc=0 and a NOP.
    assign pop_valid = (count != '0);
    assign pop_pc    = pop_valid ? head_pc    : '0;
    assign pop_instr = pop_valid ? head_instr : NOP_INSTR;

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_fetch_buffer;

    localparam int DEPTH = 4;
    localparam logic [23:0] NOP = 24'h000000;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        push_valid;
    logic        push_ready;
    logic [23:0] push_pc;
    logic [23:0] push_instr;
    logic        pop_valid;
    logic        pop_ready;
    logic [23:0] pop_pc;
    logic [23:0] pop_instr;
    logic [2:0]  count;
    logic        overflow;

    fetch_buffer #(
        .DEPTH     (DEPTH),
        .WORD_W    (24),
        .NOP_INSTR (NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_pc    (push_pc),
        .push_instr (push_instr),
        .pop_valid  (pop_valid),
        .pop_ready  (pop_ready),
        .pop_pc     (pop_pc),
        .pop_instr  (pop_instr),
        .count      (count),
        .overflow   (overflow)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard / model ----------------
    logic [47:0] exp_q[$];
    logic        ovf_m;
    int          n_vec;
    int          n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behaviour at one clock edge, from the queue's point of view.
    task automatic model_edge(input logic pv, input logic pr, input logic fl,
                              input logic [23:0] pc, input logic [23:0] instr);
        bit can_push;
        bit can_pop;
        can_push = (exp_q.size() < DEPTH);
        can_pop  = (exp_q.size() > 0);
        if (pv && !can_push) ovf_m = 1'b1;
        if (fl) begin
            exp_q.delete();
        end else begin
            if (pr && can_pop) void'(exp_q.pop_front());
            if (pv && can_push) exp_q.push_back({pc, instr});
        end
    endtask

    task automatic check_model(input string tag);
        logic [23:0] e_pc;
        logic [23:0] e_instr;
        e_pc    = (exp_q.size() > 0) ? exp_q[0][47:24] : 24'h0;
        e_instr = (exp_q.size() > 0) ? exp_q[0][23:0]  : NOP;
        chk({tag, "_count"},      {29'b0, count},      exp_q.size());
        chk({tag, "_pop_valid"},  {31'b0, pop_valid},  {31'b0, exp_q.size() > 0});
        chk({tag, "_push_ready"}, {31'b0, push_ready}, {31'b0, exp_q.size() < DEPTH});
        chk({tag, "_pop_pc"},     {8'b0, pop_pc},      {8'b0, e_pc});
        chk({tag, "_pop_instr"},  {8'b0, pop_instr},   {8'b0, e_instr});
        chk({tag, "_overflow"},   {31'b0, overflow},   {31'b0, ovf_m});
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic pv, input logic pr, input logic fl,
                        input logic [23:0] pc, input logic [23:0] instr, input string tag);
        push_valid = pv;
        pop_ready  = pr;
        flush      = fl;
        push_pc    = pc;
        push_instr = instr;
        @(posedge clk);
        model_edge(pv, pr, fl, pc, instr);
        #1;
        check_model(tag);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        pv;
        logic        pr;
        logic        fl;
        logic [23:0] pc;
        logic [23:0] instr;
        logic [2:0]  e_count;
        logic        e_pop_valid;
        logic        e_push_ready;
        logic [23:0] e_pc;
        logic [23:0] e_instr;
        logic        e_ovf;
    } vec_t;

    vec_t tbl[10];

    function automatic vec_t mk(input logic pv, input logic pr, input logic fl,
                                input logic [23:0] pc, input logic [23:0] instr,
                                input logic [2:0] c, input logic v, input logic r,
                                input logic [23:0] epc, input logic [23:0] einstr,
                                input logic o);
        vec_t t;
        t.pv = pv; t.pr = pr; t.fl = fl; t.pc = pc; t.instr = instr;
        t.e_count = c; t.e_pop_valid = v; t.e_push_ready = r;
        t.e_pc = epc; t.e_instr = einstr; t.e_ovf = o;
        return t;
    endfunction

    initial begin
        n_vec = 0;
        n_err = 0;
        ovf_m = 1'b0;
        rst = 1'b1;
        flush = 1'b0;
        push_valid = 1'b0;
        pop_ready = 1'b0;
        push_pc = '0;
        push_instr = '0;

        // Idle, fill 4 with pop stalled, overflowing 5th push, then drain 4.
        tbl[0] = mk(1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 3'd0, 1'b0, 1'b1, 24'h0, NOP, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tbl[1+i] = mk(1'b1, 1'b0, 1'b0, 24'(i), 24'hA00000 + 24'(i),
                          3'(i+1), 1'b1, (i < 3), 24'h0, 24'hA00000, 1'b0);
        end
        tbl[5] = mk(1'b1, 1'b0, 1'b0, 24'h4, 24'hA00004, 3'd4, 1'b1, 1'b0, 24'h0, 24'hA00000, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tbl[6+k] = mk(1'b0, 1'b1, 1'b0, 24'h0, 24'h0, 3'(3-k), (k < 3), 1'b1,
                          (k < 3) ? 24'(k+1) : 24'h0,
                          (k < 3) ? 24'hA00000 + 24'(k+1) : NOP, 1'b1);
        end

        #1;
        check_model("reset_async");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_model("reset_idle");

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].pv, tbl[i].pr, tbl[i].fl, tbl[i].pc, tbl[i].instr, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_count", i),      {29'b0, count},      {29'b0, tbl[i].e_count});
            chk($sformatf("tbl%0d_pop_valid", i),  {31'b0, pop_valid},  {31'b0, tbl[i].e_pop_valid});
            chk($sformatf("tbl%0d_push_ready", i), {31'b0, push_ready}, {31'b0, tbl[i].e_push_ready});
            chk($sformatf("tbl%0d_pop_pc", i),     {8'b0, pop_pc},      {8'b0, tbl[i].e_pc});
            chk($sformatf("tbl%0d_pop_instr", i),  {8'b0, pop_instr},   {8'b0, tbl[i].e_instr});
            chk($sformatf("tbl%0d_overflow", i),   {31'b0, overflow},   {31'b0, tbl[i].e_ovf});
        end

        // Streaming at occupancy 1 across several pointer wraps.
        step(1'b1, 1'b0, 1'b0, 24'd10, 24'hA0000A, "stream_prime");
        for (int i = 11; i <= 20; i++) begin
            step(1'b1, 1'b1, 1'b0, 24'(i), 24'hA00000 + 24'(i), "stream");
            chk("stream_count", {29'b0, count}, 32'd1);
            chk("stream_head", {8'b0, pop_pc}, i);
        end
        step(1'b0, 1'b1, 1'b0, 24'h0, 24'h0, "stream_drain");

        // Flush beats a concurrent push and pop.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 24'h30 + 24'(i), 24'hB00000 + 24'(i), "flush_fill");
        end
        step(1'b1, 1'b1, 1'b1, 24'h50, 24'hB00050, "flush");
        chk("flush_count", {29'b0, count}, 32'd0);
        chk("flush_pop_valid", {31'b0, pop_valid}, 32'd0);
        step(1'b1, 1'b0, 1'b0, 24'h100, 24'hB00100, "after_flush");
        chk("after_flush_head", {8'b0, pop_pc}, 32'h100);
        step(1'b0, 1'b1, 1'b0, 24'h0, 24'h0, "after_flush_pop");
        chk("after_flush_empty", {8'b0, pop_instr}, {8'b0, NOP});

        // Asynchronous reset mid-cycle with two entries and overflow set.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 24'h200 + 24'(i), 24'hC00000 + 24'(i), "pre_rst_fill");
        end
        step(1'b0, 1'b1, 1'b0, 24'h0, 24'h0, "pre_rst_pop");
        step(1'b0, 1'b1, 1'b0, 24'h0, 24'h0, "pre_rst_pop");
        push_valid = 1'b0;
        pop_ready = 1'b0;
        chk("pre_rst_count", {29'b0, count}, 32'd2);
        #2;
        rst = 1'b1;
        exp_q.delete();
        ovf_m = 1'b0;
        #1;
        check_model("mid_rst");
        #2;
        rst = 1'b0;

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic [23:0] rpc;
            rpc = 24'($urandom);
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 15) == 0), rpc, 24'($urandom), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction fetch queue between the IF stage (producer) and the ID stage (consumer) of the diad core.
- Decouples IA/IF from decode stalls (hazard or branch) by storing {pc, instr} pairs in a small FIFO with valid/ready handshakes.
- A flush discards all entries when a taken branch resolves, so wrong-path instructions never reach decode.
- Empty cycles present a NOP to decode.

Parameters:
DEPTH, 4, number of entries; power of two, minimum 2
WORD_W, 24, instruction and PC width
NOP_INSTR, 24'h000000, instruction word presented when the queue is empty

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
flush  in  1  discard all entries (taken branch); synchronous
push_valid  in  1  IF presents a fetched word
push_ready  out  1  queue can accept; registered, equals count < DEPTH
push_pc  in  WORD_W  PC of the fetched word
push_instr  in  WORD_W  fetched instruction
pop_valid  out  1  head entry valid for ID
pop_ready  in  1  ID consumes head; low during decode stall
pop_pc  out  WORD_W  head PC
pop_instr  out  WORD_W  head instruction, NOP_INSTR when empty
count  out  $clog2(DEPTH+1)  current occupancy
overflow  out  1  sticky: push_valid while !push_ready; cleared only by rst

Behaviour:
- Reset values:
  - count=0, rd_ptr=0, wr_ptr=0.
  - push_ready=1, pop_valid=0, pop_pc=0, pop_instr=NOP_INSTR, overflow=0.
- Handshakes:
  - Push fires when push_valid && push_ready.
  - Pop fires when pop_valid && pop_ready.
  - Both are evaluated at the same clk edge.
- Pointers:
  - rd_ptr and wr_ptr are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - count tracks occupancy: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop.
- Output timing:
  - Outputs are first-word fall-through: pop_valid = (count != 0).
  - pop_pc and pop_instr are a combinational read of mem[rd_ptr]; when count == 0 they are forced to 0 and NOP_INSTR.
  - Latency: a word pushed into an empty queue is visible at pop_* the cycle after the push edge.
- push_ready timing: push_ready is registered from the next-state count (next_count < DEPTH). There is no combinational path from pop_ready to push_ready.
- Full: push_ready=0, so a simultaneous pop does not allow a push in the same cycle. Any push_valid while full sets overflow; the entry is not written.
- Empty: a pop attempt is ignored. count never underflows.
- Simultaneous push+pop at count==1: the head advances to the newly pushed word; count stays 1.
- Flush:
  - Takes precedence over push and pop in the same cycle.
  - Sets count=0 and rd_ptr=wr_ptr=0; the concurrent push is dropped; push_ready=1 next cycle.
  - Storage contents are not cleared.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Entries in flight are lost.
- Storage write: mem[wr_ptr] is written on a push only, with no reset on the array. Reads of unwritten entries are masked by count.

Decomposition:
- Shared package diad_pkg holds:
  - WORD_W=24.
  - NOP_INSTR constant, matching the NOP encoding defined alongside the opcodes.
  - fetch_entry_t typedef {pc[23:0], instr[23:0]}.
- One natural sub-module: fetch_buffer_ram, a DEPTH x 48-bit register array with one write port and one asynchronous read port. Pointer and count control stays in fetch_buffer.

Test Plan:
- Reset then idle: pop_valid=0, pop_instr=24'h000000, push_ready=1, count=0.
- Push pc=0..3 with instr=24'hA00000+pc while pop_ready=0: count goes 1..4; after the 4th edge push_ready=0 and the head is pc=0 / 24'hA00000. A 5th push sets overflow=1 and count stays 4.
- From full, hold pop_ready=1 for 4 cycles with no push: pops return pc 0,1,2,3 in order. push_ready=1 after the first pop edge. The queue is empty with pop_instr=NOP after the 4th.
- Continuous push and pop at count=1 for 10 cycles (pc 10..19): count stays 1. Pop order matches push order across pointer wrap (wr_ptr passes 3 to 0 twice).
- Fill 3 entries, then flush with push_valid=1 (pc=24'h000050) and pop_ready=1 in the same cycle: next cycle count=0, pop_valid=0, and pc 24'h000050 is absent. A following push of pc=24'h000100 appears at the head one cycle later.
- Assert rst asynchronously mid-cycle with count=2: outputs go to reset values without waiting for clk, and overflow clears.
